// File: rtl/regfile_write_queue_if.sv
// Bundles the pipeline writeback, multi-cycle result handshake, hazard query
// and register-file write port of regfile_write_queue.
interface regfile_write_queue_if;
    logic        p_we;
    logic [4:0]  p_wr;
    logic [31:0] p_wd;
    logic        m_valid;
    logic        m_ready;
    logic [4:0]  m_wr;
    logic [31:0] m_wd;
    logic [4:0]  RR1;
    logic [4:0]  RR2;
    logic        pend1;
    logic        pend2;
    logic [4:0]  WR;
    logic [31:0] WD;
    logic        RegWrite;
    logic [3:0]  count;

    // Surrounding core: drives writebacks, results and queries.
    modport master (
        output p_we, p_wr, p_wd, m_valid, m_wr, m_wd, RR1, RR2,
        input  m_ready, pend1, pend2, WR, WD, RegWrite, count
    );

    // The write queue itself.
    modport slave (
        input  p_we, p_wr, p_wd, m_valid, m_wr, m_wd, RR1, RR2,
        output m_ready, pend1, pend2, WR, WD, RegWrite, count
    );
endinterface

// File: rtl/regfile_write_queue.sv
// Register-file write arbiter. The pipeline writeback owns the single write
// slot; long-latency results wait in an in-order FIFO and drain into idle
// slots. A pipeline write to register r kills every queued write to r so an
// older multi-cycle result can never overwrite a younger value.
module regfile_write_queue #(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_write_queue_if.slave bus
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Per-entry address and liveness stay in flops so they can be compared in
    // parallel for kills and hazard queries; the data payload lives in an array.
    logic [4:0]       addr_reg [DEPTH];
    logic             live_reg [DEPTH];
    logic [31:0]      data_mem [DEPTH];

    logic [PW-1:0]    head_reg;
    logic [PW-1:0]    tail_reg;
    logic [3:0]       count_reg;

    logic             wr_en_reg;
    logic [4:0]       wr_reg;
    logic [31:0]      wd_reg;

    logic             full;
    logic             pipe_acc;
    logic             push;
    logic             pop;
    logic [DEPTH-1:0] kill_hit;
    logic [DEPTH-1:0] rr1_hit;
    logic [DEPTH-1:0] rr2_hit;

    // Writes to $0 are meaningless, so they never claim the slot.
    assign pipe_acc = bus.p_we && (bus.p_wr != 5'd0);
    // Ready depends on the registered count only: a pop on the same edge does
    // not free space early.
    assign full     = (count_reg == 4'(DEPTH));
    assign push     = bus.m_valid && !full && (bus.m_wr != 5'd0);
    // The queue drains only when the pipeline leaves the slot idle.
    assign pop      = !pipe_acc && (count_reg != 4'd0);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign kill_hit[gi] = pipe_acc && (addr_reg[gi] == bus.p_wr);
            assign rr1_hit[gi]  = live_reg[gi] && (addr_reg[gi] == bus.RR1);
            assign rr2_hit[gi]  = live_reg[gi] && (addr_reg[gi] == bus.RR2);
        end
    endgenerate

    // Entry bookkeeping: pop frees the head, push fills the tail (born killed if
    // the pipeline writes the same register this edge), pipeline writes kill matches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_reg[i] <= 5'd0;
                live_reg[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (pop && (head_reg == PW'(i))) begin
                    live_reg[i] <= 1'b0;
                end else if (push && (tail_reg == PW'(i))) begin
                    addr_reg[i] <= bus.m_wr;
                    live_reg[i] <= !(pipe_acc && (bus.m_wr == bus.p_wr));
                end else if (kill_hit[i]) begin
                    live_reg[i] <= 1'b0;
                end
            end
        end
    end

    // Payload storage; no reset needed because liveness gates every use.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[tail_reg] <= bus.m_wd;
        end
    end

    // Pointer and occupancy update; killed entries still occupy space until popped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= 4'd0;
        end else begin
            if (push) begin
                tail_reg <= tail_reg + PW'(1);
            end
            if (pop) begin
                head_reg <= head_reg + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 4'd1;
                2'b01:   count_reg <= count_reg - 4'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Write slot: pipeline first, then a live FIFO head; a killed head burns the
    // slot silently. WR/WD hold whenever RegWrite drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_reg <= 1'b0;
            wr_reg    <= 5'd0;
            wd_reg    <= 32'd0;
        end else if (pipe_acc) begin
            wr_en_reg <= 1'b1;
            wr_reg    <= bus.p_wr;
            wd_reg    <= bus.p_wd;
        end else if (pop && live_reg[head_reg]) begin
            wr_en_reg <= 1'b1;
            wr_reg    <= addr_reg[head_reg];
            wd_reg    <= data_mem[head_reg];
        end else begin
            wr_en_reg <= 1'b0;
        end
    end

    // A register is pending while a live queued write targets it or the write
    // port is about to commit it on the next negedge.
    assign bus.pend1 = (bus.RR1 != 5'd0) &&
                       ((|rr1_hit) || (wr_en_reg && (wr_reg == bus.RR1)));
    assign bus.pend2 = (bus.RR2 != 5'd0) &&
                       ((|rr2_hit) || (wr_en_reg && (wr_reg == bus.RR2)));

    assign bus.m_ready  = !full;
    assign bus.count    = count_reg;
    assign bus.RegWrite = wr_en_reg;
    assign bus.WR       = wr_reg;
    assign bus.WD       = wd_reg;

endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed and randomized check of regfile_write_queue against a queue-based
// reference model of the write-slot arbitration and kill rules.
module tb_regfile_write_queue;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;

    regfile_write_queue_if bus();

    regfile_write_queue #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        bit          live;
    } ent_t;

    ent_t        q[$];
    bit          e_rw;
    logic [4:0]  e_wr;
    logic [31:0] e_wd;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        e_rw = 1'b0;
        e_wr = 5'd0;
        e_wd = 32'd0;
    endtask

    // One clock edge of the reference behaviour, using the inputs as driven.
    task automatic model_edge();
        ent_t e;
        bit   pacc;
        bit   rdy;
        pacc = bus.p_we && (bus.p_wr != 5'd0);
        rdy  = (q.size() < DEPTH);
        if (pacc) begin
            foreach (q[i]) if (q[i].a == bus.p_wr) q[i].live = 1'b0;
            e_rw = 1'b1;
            e_wr = bus.p_wr;
            e_wd = bus.p_wd;
        end else if (q.size() > 0) begin
            e = q.pop_front();
            e_rw = e.live;
            if (e.live) begin
                e_wr = e.a;
                e_wd = e.d;
            end
        end else begin
            e_rw = 1'b0;
        end
        if (bus.m_valid && rdy && (bus.m_wr != 5'd0)) begin
            e.a    = bus.m_wr;
            e.d    = bus.m_wd;
            e.live = !(pacc && (bus.m_wr == bus.p_wr));
            q.push_back(e);
        end
    endtask

    function automatic bit pend_exp(input logic [4:0] rr);
        if (rr == 5'd0) return 1'b0;
        foreach (q[i]) if (q[i].live && (q[i].a == rr)) return 1'b1;
        return e_rw && (e_wr == rr);
    endfunction

    task automatic compare_all(input string p);
        chk({p, ".RegWrite"}, 32'(bus.RegWrite), 32'(e_rw));
        chk({p, ".WR"},       32'(bus.WR),       32'(e_wr));
        chk({p, ".WD"},       bus.WD,            e_wd);
        chk({p, ".count"},    32'(bus.count),    32'(q.size()));
        chk({p, ".m_ready"},  32'(bus.m_ready),  32'(q.size() < DEPTH));
        chk({p, ".pend1"},    32'(bus.pend1),    32'(pend_exp(bus.RR1)));
        chk({p, ".pend2"},    32'(bus.pend2),    32'(pend_exp(bus.RR2)));
    endtask

    task automatic drive(input logic pwe, input logic [4:0] pwr, input logic [31:0] pwd,
                         input logic mv, input logic [4:0] mwr, input logic [31:0] mwd);
        bus.p_we    = pwe;
        bus.p_wr    = pwr;
        bus.p_wd    = pwd;
        bus.m_valid = mv;
        bus.m_wr    = mwr;
        bus.m_wd    = mwd;
    endtask

    task automatic cycle(input string p);
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        $display("cyc %0d p_we=%0b p_wr=%0d m_valid=%0b m_wr=%0d -> RegWrite=%0b WR=%0d WD=%h count=%0d m_ready=%0b pend=%0b%0b",
                 cyc, bus.p_we, bus.p_wr, bus.m_valid, bus.m_wr,
                 bus.RegWrite, bus.WR, bus.WD, bus.count, bus.m_ready, bus.pend1, bus.pend2);
        compare_all(p);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        bus.RR1 = 5'd9;
        bus.RR2 = 5'd3;
        model_reset();
        #1;
        compare_all("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single pipeline write, then idle.
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        cycle("pipe1");
        chk("pipe1.WR_const", 32'(bus.WR), 32'd5);
        chk("pipe1.WD_const", bus.WD, 32'hDEADBEEF);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        cycle("pipe1_idle");
        chk("pipe1_idle.RegWrite_const", 32'(bus.RegWrite), 32'd0);

        // Fill the queue behind a busy pipeline, then drain in order.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd2, 32'h2, 1'b1, 5'(8 + i), 32'(8 + i));
            cycle("fill");
        end
        chk("fill.count_const", 32'(bus.count), 32'd4);
        chk("fill.m_ready_const", 32'(bus.m_ready), 32'd0);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            cycle("drain");
            chk("drain.WR_const", 32'(bus.WR), 32'(8 + i));
            chk("drain.RegWrite_const", 32'(bus.RegWrite), 32'd1);
            if (i == 0) chk("drain.m_ready_const", 32'(bus.m_ready), 32'd1);
        end
        cycle("drain_idle");

        // Writes to $0 from both sources are dropped.
        drive(1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 32'h5678);
        chk("zero.m_ready_pre", 32'(bus.m_ready), 32'd1);
        cycle("zero");
        chk("zero.RegWrite_const", 32'(bus.RegWrite), 32'd0);
        chk("zero.count_const", 32'(bus.count), 32'd0);

        // Kill: queue $8 and $9=0x11, then pipeline writes $9=0x22.
        bus.RR1 = 5'd9;
        bus.RR2 = 5'd8;
        drive(1'b1, 5'd3, 32'h3, 1'b1, 5'd8, 32'h8);
        cycle("kill_q8");
        drive(1'b1, 5'd3, 32'h3, 1'b1, 5'd9, 32'h11);
        cycle("kill_q9");
        drive(1'b1, 5'd9, 32'h22, 1'b0, 5'd0, 32'd0);
        cycle("kill_pipe");
        chk("kill_pipe.pend1_const", 32'(bus.pend1), 32'd1);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        cycle("kill_pop8");
        chk("kill_pop8.pend1_const", 32'(bus.pend1), 32'd0);
        cycle("kill_pop9");
        chk("kill_pop9.RegWrite_const", 32'(bus.RegWrite), 32'd0);
        chk("kill_pop9.count_const", 32'(bus.count), 32'd0);

        // Hazard query on a queued $7.
        bus.RR1 = 5'd7;
        bus.RR2 = 5'd0;
        drive(1'b1, 5'd4, 32'h4, 1'b1, 5'd7, 32'h77);
        cycle("pend_push");
        chk("pend_push.pend1_const", 32'(bus.pend1), 32'd1);
        chk("pend_push.pend2_const", 32'(bus.pend2), 32'd0);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        cycle("pend_pop");
        cycle("pend_after");
        chk("pend_after.pend1_const", 32'(bus.pend1), 32'd0);

        // Asynchronous reset with three entries queued.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd1, 32'h1, 1'b1, 5'(3 + i), 32'(16 + i));
            cycle("prerst");
        end
        chk("prerst.count_const", 32'(bus.count), 32'd3);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        bus.RR1 = 5'd3;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all("async_rst");
        chk("async_rst.count_const", 32'(bus.count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle("postrst");
            chk("postrst.RegWrite_const", 32'(bus.RegWrite), 32'd0);
        end

        // Randomized traffic with a small register range to force collisions.
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom);
            bus.RR1 = 5'($urandom_range(0, 7));
            bus.RR2 = 5'($urandom_range(0, 7));
            cycle("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
